// File: rtl/tx_serial_7o1_uc.sv
// tx_serial_7o1_uc: control unit for the 7O1 serial transmitter, with its own baud-tick divider
module tx_serial_7o1_uc #(
  parameter int M_TICK = 434,
  parameter int N_TICK = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic       fim,
  output logic       zera,
  output logic       carrega,
  output logic       desloca,
  output logic       conta,
  output logic       pronto,
  output logic       ocupado,
  output logic [3:0] db_estado
);
  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARACAO  = 4'd1,
    ESPERA      = 4'd2,
    TRANSMISSAO = 4'd3,
    FINAL       = 4'd4
  } state_t;
  state_t state, next;
  logic [N_TICK-1:0] cnt;
  logic tick;
  assign tick = cnt == N_TICK'(M_TICK - 1);
  always_ff @(posedge clock)
    if (reset) state <= INICIAL;
    else state <= next;
  always_ff @(posedge clock)
    if (reset || state == PREPARACAO) cnt <= '0;
    else if (state == ESPERA || state == TRANSMISSAO) cnt <= tick ? '0 : cnt + N_TICK'(1);
  always_comb begin
    next      = INICIAL;
    zera      = 1'b0;
    carrega   = 1'b0;
    desloca   = 1'b0;
    conta     = 1'b0;
    pronto    = 1'b0;
    ocupado   = 1'b0;
    next      = state == INICIAL     ? (partida ? PREPARACAO : INICIAL) :
                state == PREPARACAO  ? ESPERA :
                state == ESPERA      ? (fim ? FINAL : tick ? TRANSMISSAO : ESPERA) :
                state == TRANSMISSAO ? ESPERA : INICIAL;
    zera      = state == PREPARACAO;
    carrega   = state == PREPARACAO;
    desloca   = state == TRANSMISSAO;
    conta     = state == TRANSMISSAO;
    pronto    = state == FINAL;
    ocupado   = state == PREPARACAO || state == ESPERA || state == TRANSMISSAO;
  end
  assign db_estado = state;
endmodule

// File: tb/tb_tx_serial_7o1_uc.sv
// tb_tx_serial_7o1_uc: self-checking bench for the 7O1 transmitter control unit
module tb_tx_serial_7o1_uc;
  localparam int M = 4;
  localparam int LAST = 11 * M + 4;
  typedef struct {
    int         edge_n;
    logic [3:0] st;
    logic       line;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic partida = 1'b0;
  logic fim_force = 1'b0;
  logic fim;
  logic zera, carrega, desloca, conta, pronto, ocupado;
  logic [3:0] db_estado;
  logic [6:0] dados = 7'h41;
  logic [10:0] sr = '1;
  int off = 0;
  int bitcnt = 0;
  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;
  vec_t tbl[16];
  always #5 clk = ~clk;
  tx_serial_7o1_uc #(.M_TICK(M), .N_TICK(3)) dut (
    .clock(clk), .reset(reset), .partida(partida), .fim(fim),
    .zera(zera), .carrega(carrega), .desloca(desloca), .conta(conta),
    .pronto(pronto), .ocupado(ocupado), .db_estado(db_estado)
  );
  assign fim = (bitcnt == 11) || fim_force;
  always @(posedge clk) begin
    if (reset) begin
      off    <= 0;
      bitcnt <= 0;
      sr     <= '1;
    end else begin
      off    <= off == 0 ? (partida ? 1 : 0) : off == LAST ? 0 : off + 1;
      bitcnt <= zera ? 0 : conta ? bitcnt + 1 : bitcnt;
      sr     <= carrega ? {1'b1, ~^dados, dados, 1'b0, 1'b1} : desloca ? {1'b1, sr[10:1]} : sr;
    end
  end
  function automatic logic [9:0] expect_out(int o);
    logic [3:0] st;
    st = o == 0 ? 4'd0 : o == 1 ? 4'd1 : o == LAST ? 4'd4 :
         (o >= M + 2 && o <= 11 * M + 2 && (o - M - 2) % M == 0) ? 4'd3 : 4'd2;
    return {st, st == 1, st == 1, st == 3, st == 3, st == 4, st inside {4'd1, 4'd2, 4'd3}};
  endfunction
  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
    if (chk_en) check("model", {db_estado, zera, carrega, desloca, conta, pronto, ocupado}, expect_out(off));
  endtask
  task automatic run_frame(input bit repulse);
    int n_shift, n_load;
    n_shift = 0;
    n_load = 0;
    partida = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      cyc();
      partida = repulse && (c == 9 || c == 29);
      n_shift += desloca;
      n_load += carrega && zera;
      foreach (tbl[i])
        if (tbl[i].edge_n == c)
          check($sformatf("table_e%0d", c), {5'd0, db_estado, sr[0]}, {5'd0, tbl[i].st, tbl[i].line});
    end
    check("shift_count", 10'(n_shift), 10'd11);
    check("load_count", 10'(n_load), 10'd1);
  endtask
  initial begin
    tbl = '{
      '{1, 4'd1, 1'b1}, '{2, 4'd2, 1'b1}, '{6, 4'd3, 1'b1}, '{7, 4'd2, 1'b0},
      '{11, 4'd2, 1'b1}, '{15, 4'd2, 1'b0}, '{19, 4'd2, 1'b0}, '{23, 4'd2, 1'b0},
      '{27, 4'd2, 1'b0}, '{31, 4'd2, 1'b0}, '{35, 4'd2, 1'b1}, '{39, 4'd2, 1'b1},
      '{43, 4'd2, 1'b1}, '{47, 4'd2, 1'b1}, '{48, 4'd4, 1'b1}, '{49, 4'd0, 1'b1}
    };
    @(negedge clk);
    cyc();
    chk_en = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_line", {9'd0, sr[0]}, 10'd1);
    end
    run_frame(1'b0);
    run_frame(1'b1);
    partida = 1'b1;
    repeat (19) cyc();
    partida = 1'b0;
    reset = 1'b1;
    cyc();
    check("abort_state", {6'd0, db_estado}, 10'd0);
    check("abort_line", {9'd0, sr[0]}, 10'd1);
    reset = 1'b0;
    cyc();
    run_frame(1'b0);
    chk_en = 1'b0;
    fim_force = 1'b1;
    partida = 1'b1;
    cyc();
    partida = 1'b0;
    check("fim_prio_e1", {6'd0, db_estado}, 10'd1);
    cyc();
    check("fim_prio_e2", {6'd0, db_estado}, 10'd2);
    cyc();
    check("fim_prio_e3", {6'd0, db_estado}, 10'd4);
    cyc();
    check("fim_prio_e4", {6'd0, db_estado}, 10'd0);
    fim_force = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_en = 1'b1;
    begin
      int n_pronto, first_p, second_p;
      n_pronto = 0;
      first_p = 0;
      second_p = 0;
      partida = 1'b1;
      for (int c = 1; c <= 120; c++) begin
        cyc();
        if (pronto) begin
          n_pronto++;
          if (n_pronto == 1) first_p = c;
          if (n_pronto == 2) second_p = c;
        end
      end
      partida = 1'b0;
      check("held_pronto_count", 10'(n_pronto), 10'd2);
      check("held_pronto_first", 10'(first_p), 10'd48);
      check("held_pronto_gap", 10'(second_p - first_p), 10'(11 * M + 5));
      repeat (60) cyc();
    end
    for (int i = 0; i < 1500; i++) begin
      partida = $urandom_range(0, 15) == 0;
      reset = $urandom_range(0, 399) == 0;
      if (off == 0) dados = 7'($urandom);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
